ana_in_cap_seq: RTL and testbench

//  Parametrised multi-channel sequencer for analog-input pad sampling capacitors.
//  Per request: discharges the selected channel's cap to GNDADR, breaks before make,

---
 rtl/ana_in_cap_seq_if.sv | 34 +++
 rtl/ana_in_cap_seq.sv | 144 ++++++++++++++
 tb/tb_ana_in_cap_seq.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/ana_in_cap_seq_if.sv
// Handshake and switch-control bundle between the ADC controller, the
// pad-cap sequencer and the pad-cap switch cells.
interface ana_in_cap_seq_if #(
    parameter int NCH      = 4,
    parameter int SETTLE_W = 8
);
    localparam int CH_W = $clog2(NCH);

    logic                REQ_VALID;
    logic                REQ_READY;
    logic [CH_W-1:0]     REQ_CH;
    logic [SETTLE_W-1:0] SETTLE_CNT;
    logic                ABORT;
    logic [NCH-1:0]      DISCH_EN;
    logic [NCH-1:0]      CONN_EN;
    logic                SAMPLE;
    logic [CH_W-1:0]     SMP_CH;
    logic                DONE_VALID;
    logic                DONE_READY;
    logic                ERR;
    logic                ERR_CLR;

    // ADC controller side
    modport master (
        output REQ_VALID, REQ_CH, SETTLE_CNT, ABORT, DONE_READY, ERR_CLR,
        input  REQ_READY, DISCH_EN, CONN_EN, SAMPLE, SMP_CH, DONE_VALID, ERR
    );

    // Sequencer side
    modport slave (
        input  REQ_VALID, REQ_CH, SETTLE_CNT, ABORT, DONE_READY, ERR_CLR,
        output REQ_READY, DISCH_EN, CONN_EN, SAMPLE, SMP_CH, DONE_VALID, ERR
    );
endinterface

// File: rtl/ana_in_cap_seq.sv
// Multi-channel pad sampling-cap sequencer: discharge, break-before-make gap,
// connect/settle, sample strobe, then hold DONE until the ADC acknowledges.
module ana_in_cap_seq #(
    parameter int NCH       = 4,
    parameter int SETTLE_W  = 8,
    parameter int DISCH_CYC = 4
) (
    input  logic              CLK,
    input  logic              RESETB,
    ana_in_cap_seq_if.slave   bus
);
    localparam int CH_W = $clog2(NCH);
    localparam int DC_W = $clog2(DISCH_CYC + 1);
    localparam logic [CH_W:0]    NCH_EXT = (CH_W+1)'(NCH);
    localparam logic [NCH-1:0]   OH_BASE = {{(NCH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DISCH = 3'd1,
        ST_GAP   = 3'd2,
        ST_CONN  = 3'd3,
        ST_SMPL  = 3'd4,
        ST_HOLD  = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [DC_W-1:0]     disch_cnt_q, disch_cnt_d;
    logic                err_q, err_d;
    logic [NCH-1:0]      disch_en_q, disch_en_d;
    logic [NCH-1:0]      conn_en_q, conn_en_d;
    logic                sample_q, sample_d;
    logic                done_valid_q, done_valid_d;
    logic                accept_s;
    logic                bad_ch_s;

    assign bus.REQ_READY  = (state_q == ST_IDLE) & ~bus.ABORT;
    assign accept_s       = bus.REQ_VALID & bus.REQ_READY;
    assign bad_ch_s       = ({1'b0, bus.REQ_CH} >= NCH_EXT);

    assign bus.DISCH_EN   = disch_en_q;
    assign bus.CONN_EN    = conn_en_q;
    assign bus.SAMPLE     = sample_q;
    assign bus.SMP_CH     = ch_q;
    assign bus.DONE_VALID = done_valid_q;
    assign bus.ERR        = err_q;

    // Next-state, counter and output decode; outputs derive from the next state so
    // the registered switch enables line up with the registered state.
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        settle_d    = settle_q;
        disch_cnt_d = disch_cnt_q;
        err_d       = err_q;

        if (accept_s && bad_ch_s) begin
            err_d = 1'b1;
        end else if (bus.ERR_CLR) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end

        if (bus.ABORT && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s && !bad_ch_s) begin
                        state_d     = ST_DISCH;
                        ch_d        = bus.REQ_CH;
                        settle_d    = (bus.SETTLE_CNT == '0) ? SETTLE_W'(1) : bus.SETTLE_CNT;
                        disch_cnt_d = DC_W'(DISCH_CYC);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DISCH: begin
                    if (disch_cnt_q <= DC_W'(1)) begin
                        state_d = ST_GAP;
                    end else begin
                        disch_cnt_d = disch_cnt_q - DC_W'(1);
                    end
                end
                ST_GAP: begin
                    state_d = ST_CONN;
                end
                ST_CONN: begin
                    // Settle count stops at 1 rather than wrapping.
                    if (settle_q <= SETTLE_W'(1)) begin
                        state_d = ST_SMPL;
                    end else begin
                        settle_d = settle_q - SETTLE_W'(1);
                    end
                end
                ST_SMPL: begin
                    state_d = ST_HOLD;
                end
                ST_HOLD: begin
                    if (bus.DONE_READY) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        disch_en_d   = (state_d == ST_DISCH) ? (OH_BASE << ch_d) : '0;
        conn_en_d    = ((state_d == ST_CONN) || (state_d == ST_SMPL)) ? (OH_BASE << ch_d) : '0;
        sample_d     = (state_d == ST_SMPL);
        done_valid_d = (state_d == ST_HOLD);
    end

    // State, counters and registered outputs; async reset opens every switch at once.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            state_q      <= ST_IDLE;
            ch_q         <= '0;
            settle_q     <= '0;
            disch_cnt_q  <= '0;
            err_q        <= 1'b0;
            disch_en_q   <= '0;
            conn_en_q    <= '0;
            sample_q     <= 1'b0;
            done_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            settle_q     <= settle_d;
            disch_cnt_q  <= disch_cnt_d;
            err_q        <= err_d;
            disch_en_q   <= disch_en_d;
            conn_en_q    <= conn_en_d;
            sample_q     <= sample_d;
            done_valid_q <= done_valid_d;
        end
    end
endmodule

// File: tb/tb_ana_in_cap_seq.sv
// Directed bench for ana_in_cap_seq: cycle table for the nominal and abort
// sequences, hand sequences for settle limits, bad channels and async reset.
module tb_ana_in_cap_seq;
    logic CLK;
    logic RESETB;
    int   n_tests = 0;
    int   n_fail  = 0;

    ana_in_cap_seq_if #(.NCH(4), .SETTLE_W(8)) bus4 ();
    ana_in_cap_seq_if #(.NCH(3), .SETTLE_W(8)) bus3 ();

    ana_in_cap_seq #(.NCH(4), .SETTLE_W(8), .DISCH_CYC(4)) dut4 (
        .CLK(CLK), .RESETB(RESETB), .bus(bus4)
    );
    ana_in_cap_seq #(.NCH(3), .SETTLE_W(8), .DISCH_CYC(4)) dut3 (
        .CLK(CLK), .RESETB(RESETB), .bus(bus3)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic       valid;
        logic [1:0] ch;
        logic [7:0] settle;
        logic       abort;
        logic       dr;
        logic [3:0] e_disch;
        logic [3:0] e_conn;
        logic       e_sample;
        logic       e_dv;
        logic       e_rdy;
        logic [1:0] e_ch;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic [1:0] c, logic [7:0] s, logic ab, logic d,
                                logic [3:0] ed, logic [3:0] ec, logic es, logic edv,
                                logic er, logic [1:0] ech);
        vec_t r;
        r.valid = v; r.ch = c; r.settle = s; r.abort = ab; r.dr = d;
        r.e_disch = ed; r.e_conn = ec; r.e_sample = es; r.e_dv = edv;
        r.e_rdy = er; r.e_ch = ech;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // One full request on the NCH=4 instance, measuring every phase cycle by cycle.
    task automatic run_req(input logic [1:0] ch, input logic [7:0] s, input int dly,
                           output int dw, output int cw, output int smp, output int viol,
                           output int tmo, output int dv_ok, output int end_ok);
        logic [3:0] oh;
        logic       prev_d;
        oh = 4'b0001 << ch;
        dw = 0; cw = 0; smp = 0; viol = 0; tmo = 1; dv_ok = 1; end_ok = 0;
        prev_d = 1'b0;
        step();
        bus4.REQ_VALID = 1'b1; bus4.REQ_CH = ch; bus4.SETTLE_CNT = s;
        step();
        bus4.REQ_VALID = 1'b0;
        #1;
        for (int c = 0; c < 600; c++) begin
            if (bus4.DISCH_EN != 4'b0000) dw++;
            if (bus4.CONN_EN != 4'b0000) cw++;
            if (bus4.SAMPLE) smp++;
            if ((bus4.DISCH_EN != 4'b0000) && (bus4.DISCH_EN != oh)) viol++;
            if ((bus4.CONN_EN != 4'b0000) && (bus4.CONN_EN != oh)) viol++;
            if ((bus4.DISCH_EN != 4'b0000) && (bus4.CONN_EN != 4'b0000)) viol++;
            if ((bus4.CONN_EN != 4'b0000) && prev_d) viol++;
            prev_d = (bus4.DISCH_EN != 4'b0000);
            if (bus4.DONE_VALID) begin
                tmo = 0;
                break;
            end
            step();
        end
        if (tmo == 0) begin
            for (int k = 0; k < dly; k++) begin
                step();
                if (!bus4.DONE_VALID) dv_ok = 0;
                if ((bus4.DISCH_EN | bus4.CONN_EN) != 4'b0000) viol++;
            end
            bus4.DONE_READY = 1'b1;
            step();
            bus4.DONE_READY = 1'b0;
            #1;
            end_ok = (bus4.REQ_READY && !bus4.DONE_VALID) ? 1 : 0;
        end
    endtask

    task automatic check_req(input string tag, input logic [1:0] ch, input logic [7:0] s,
                             input int dly);
        int dw, cw, smp, viol, tmo, dv_ok, end_ok;
        int s_eff;
        s_eff = (s == 8'd0) ? 1 : int'(s);
        run_req(ch, s, dly, dw, cw, smp, viol, tmo, dv_ok, end_ok);
        chk({tag, " timeout"}, 32'(tmo), 32'd0);
        chk({tag, " disch_width"}, 32'(dw), 32'd4);
        chk({tag, " conn_width"}, 32'(cw), 32'(s_eff + 1));
        chk({tag, " samples"}, 32'(smp), 32'd1);
        chk({tag, " switch_violations"}, 32'(viol), 32'd0);
        chk({tag, " done_held"}, 32'(dv_ok), 32'd1);
        chk({tag, " ready_after_ack"}, 32'(end_ok), 32'd1);
        chk({tag, " smp_ch"}, 32'(bus4.SMP_CH), 32'(ch));
    endtask

    initial begin
        RESETB = 1'b0;
        bus4.REQ_VALID = 1'b0; bus4.REQ_CH = 2'd0; bus4.SETTLE_CNT = 8'd0;
        bus4.ABORT = 1'b0; bus4.DONE_READY = 1'b0; bus4.ERR_CLR = 1'b0;
        bus3.REQ_VALID = 1'b0; bus3.REQ_CH = 2'd0; bus3.SETTLE_CNT = 8'd0;
        bus3.ABORT = 1'b0; bus3.DONE_READY = 1'b0; bus3.ERR_CLR = 1'b0;
        repeat (2) @(posedge CLK);
        #3 RESETB = 1'b1;
        #1;
        chk("reset ready", 32'(bus4.REQ_READY), 32'd1);
        chk("reset disch", 32'(bus4.DISCH_EN), 32'd0);
        chk("reset conn", 32'(bus4.CONN_EN), 32'd0);
        chk("reset sample_dv", 32'({bus4.SAMPLE, bus4.DONE_VALID}), 32'd0);
        chk("reset err_ch", 32'({bus4.ERR, bus4.SMP_CH}), 32'd0);

        // Nominal ch2, settle 3, ack in cycle 12
        vecs.push_back(mk(1, 2, 3, 0, 0, 4'b0000, 4'b0000, 0, 0, 1, 0));
        for (int i = 1; i <= 4; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0100, 4'b0000, 0, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 2));
        for (int i = 6; i <= 8; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 4'b0100, 0, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 4'b0100, 1, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 1, 4'b0000, 4'b0000, 0, 1, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 1, 2));
        // Same request, aborted in cycle 7 of the connect phase
        vecs.push_back(mk(1, 2, 3, 0, 0, 4'b0000, 4'b0000, 0, 0, 1, 2));
        for (int i = 1; i <= 4; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0100, 4'b0000, 0, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 4'b0100, 0, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 1, 0, 4'b0000, 4'b0100, 0, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 1, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 1, 2));
        // Abort while idle blocks the request
        vecs.push_back(mk(1, 1, 2, 1, 0, 4'b0000, 4'b0000, 0, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 1, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 1, 2));

        foreach (vecs[i]) begin
            step();
            bus4.REQ_VALID = vecs[i].valid; bus4.REQ_CH = vecs[i].ch;
            bus4.SETTLE_CNT = vecs[i].settle; bus4.ABORT = vecs[i].abort;
            bus4.DONE_READY = vecs[i].dr;
            #1;
            chk($sformatf("row%0d disch", i), 32'(bus4.DISCH_EN), 32'(vecs[i].e_disch));
            chk($sformatf("row%0d conn", i), 32'(bus4.CONN_EN), 32'(vecs[i].e_conn));
            chk($sformatf("row%0d sample", i), 32'(bus4.SAMPLE), 32'(vecs[i].e_sample));
            chk($sformatf("row%0d done_valid", i), 32'(bus4.DONE_VALID), 32'(vecs[i].e_dv));
            chk($sformatf("row%0d req_ready", i), 32'(bus4.REQ_READY), 32'(vecs[i].e_rdy));
            chk($sformatf("row%0d smp_ch", i), 32'(bus4.SMP_CH), 32'(vecs[i].e_ch));
            chk($sformatf("row%0d err", i), 32'(bus4.ERR), 32'd0);
        end
        bus4.REQ_VALID = 1'b0; bus4.ABORT = 1'b0; bus4.DONE_READY = 1'b0;

        // Settle limits, top channel, then randomised back-to-back requests
        check_req("settle0", 2'd0, 8'd0, 0);
        check_req("settle255", 2'd0, 8'd255, 1);
        check_req("ch3", 2'd3, 8'd2, 0);
        for (int k = 0; k < 6; k++) begin
            check_req($sformatf("rnd%0d", k), 2'($urandom_range(3, 0)),
                      8'($urandom_range(12, 0)), int'($urandom_range(3, 0)));
        end

        // Out-of-range channel on the 3-channel build
        step();
        bus3.REQ_VALID = 1'b1; bus3.REQ_CH = 2'd3; bus3.SETTLE_CNT = 8'd1;
        #1 chk("bad ready", 32'(bus3.REQ_READY), 32'd1);
        step();
        bus3.REQ_VALID = 1'b0;
        #1;
        chk("bad err_set", 32'(bus3.ERR), 32'd1);
        chk("bad no_switch", 32'({bus3.DISCH_EN, bus3.CONN_EN}), 32'd0);
        chk("bad stays_idle", 32'(bus3.REQ_READY), 32'd1);
        step();
        #1 chk("bad no_switch2", 32'({bus3.DISCH_EN, bus3.CONN_EN}), 32'd0);
        bus3.ERR_CLR = 1'b1; bus3.REQ_VALID = 1'b1;
        step();
        bus3.ERR_CLR = 1'b0; bus3.REQ_VALID = 1'b0;
        #1 chk("err set_beats_clr", 32'(bus3.ERR), 32'd1);
        bus3.ERR_CLR = 1'b1;
        step();
        bus3.ERR_CLR = 1'b0;
        #1 chk("err cleared", 32'(bus3.ERR), 32'd0);
        bus3.REQ_VALID = 1'b1;
        step();
        bus3.REQ_VALID = 1'b0;
        #1 chk("err reset_again", 32'(bus3.ERR), 32'd1);

        // Async reset in the middle of discharge
        step();
        bus4.REQ_VALID = 1'b1; bus4.REQ_CH = 2'd1; bus4.SETTLE_CNT = 8'd2;
        step();
        bus4.REQ_VALID = 1'b0;
        #1 chk("rst pre_disch", 32'(bus4.DISCH_EN), 32'h2);
        #2 RESETB = 1'b0;
        #1;
        chk("rst async_disch", 32'(bus4.DISCH_EN), 32'd0);
        chk("rst async_conn", 32'(bus4.CONN_EN), 32'd0);
        @(posedge CLK);
        #3 RESETB = 1'b1;
        #1;
        chk("rst ready", 32'(bus4.REQ_READY), 32'd1);
        chk("rst err3", 32'(bus3.ERR), 32'd0);
        chk("rst smp_ch", 32'(bus4.SMP_CH), 32'd0);
        step();
        #1 chk("rst stays_idle", 32'({bus4.DISCH_EN, bus4.CONN_EN, bus4.REQ_READY}), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
